rob_commit: RTL and testbench
=============================

# rob_commit

Reorder buffer for the out-of-order core. Allocates an in-order tag per decoded instruction and captures results broadcast on the CDB. Retires completed entries strictly in program order, driving the regfile's commit port (`ROB_data_valid` / `ROB_reg_dest` / `ROB_tag` / `ROB_data`). On a retiring branch whose prediction was wrong, it raises the pipeline-wide `clear` with the recovery PC.

## Interface
Parameters:
- `ROB_DEPTH`, 16: number of entries, power of two.
- `TAG_W`, 4: tag width, log2(`ROB_DEPTH`); matches `TagBus`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `rdy`, in, 1: global enable; when low, all state is frozen.
- `ID_alloc_valid`, in, 1: ID requests an entry this cycle.
- `ID_alloc_reg_dest`, in, 5: destination register; 0 means no write.
- `ID_alloc_is_branch`, in, 1: the instruction is a conditional branch.
- `ID_alloc_pred_taken`, in, 1: predicted direction for a branch.
- `ROB_alloc_tag`, out, `TAG_W`: tag granted this cycle (equals tail); goes to ID and regfile `ID_reg_dest_reorder`.
- `ROB_full`, out, 1: no free entry; ID must stall.
- `CDB_valid`, in, 1: result broadcast.
- `CDB_tag`, in, `TAG_W`: producing entry.
- `CDB_data`, in, 32: result value.
- `CDB_taken`, in, 1: actual branch direction.
- `CDB_pc`, in, 32: correct next PC for a branch.
- `ROB_data_valid`, out, 1: commit pulse to regfile.
- `ROB_reg_dest`, out, 5: committed destination.
- `ROB_tag`, out, `TAG_W`: committed tag.
- `ROB_data`, out, 32: committed value.
- `clear`, out, 1: mispredict flush pulse.
- `clear_pc`, out, 32: fetch restart PC.

## Operation
- Per-entry state:
  - `busy`
  - `ready`
  - `reg_dest[4:0]`
  - `is_branch`
  - `pred_taken`
  - `taken`
  - `data[31:0]`
  - `pc[31:0]`
- Pointers and counter: `head`, `tail` (`TAG_W` bits, natural wrap at `ROB_DEPTH`) and `count` (`TAG_W+1` bits).
- Full and empty:
  - `ROB_full` = (`count` == `ROB_DEPTH`), combinational.
  - Empty = (`count` == 0).
- Allocate: when `ID_alloc_valid & rdy & !ROB_full & !clear`:
  - entry[`tail`] gets `busy`=1, `ready`=0 and the ID fields;
  - `tail` <= `tail`+1.
  - An allocation request while full is ignored (no state change).
- Writeback: when `CDB_valid & rdy` and entry[`CDB_tag`].`busy`, the entry gets `ready`=1 and stores `data`, `taken` and `pc`. A CDB hit on a non-busy entry is ignored.
- Commit: when `rdy`, not empty, and entry[`head`].`busy & ready`, the next edge does the following:
  - registers `ROB_data_valid`=1, `ROB_reg_dest`, `ROB_tag`=`head` and `ROB_data`;
  - clears `busy` on the head entry;
  - `head` <= `head`+1.
- Otherwise `ROB_data_valid` <= 0. `ROB_reg_dest` is driven 0 for branches, so the regfile does no write.
- At most one commit per cycle.
- Mispredict: if the committing entry has `is_branch` and `taken` != `pred_taken`, the same edge registers `clear`=1 and `clear_pc` = entry `pc`. The cycle in which `clear` is high, the following edge:
  - sets `head` = `tail` = `count` = 0;
  - clears all `busy`;
  - forces `ROB_data_valid` = 0;
  - ignores any allocation or writeback.
- Counter update: `count` += alloc − commit. A simultaneous alloc and commit leaves `count` unchanged. Allocating into the slot being freed in the same cycle is legal when full-minus-commit.

## Timing
- Reset (async, `rst_n` low) sets:
  - `head`, `tail`, `count` = 0;
  - all `busy`/`ready` = 0;
  - `ROB_data_valid`, `ROB_reg_dest`, `ROB_tag`, `ROB_data`, `clear`, `clear_pc` = 0;
  - `ROB_alloc_tag` = 0 and `ROB_full` = 0.
- Reset mid-operation discards all entries immediately.
- `ROB_alloc_tag` and `ROB_full` are combinational from registered state; the tag is valid in the same cycle as `ID_alloc_valid`.
- Minimum latency:
  - alloc at edge E0 → CDB at earliest in the cycle after E0 → ready at E1 → `ROB_data_valid` visible after E2.
  - A CDB result for the head does not commit in the same edge it is written.
- `clear` is a one-cycle pulse. `ROB_data_valid` and `clear` are never both high.
- With `rdy` low, all registers hold, except that `ROB_data_valid` and `clear` remain as last registered (no new edges act).

## Configuration
- `ROB_CDB2_EN` defined adds a second writeback port `CDB2_valid` / `CDB2_tag` / `CDB2_data` (LSB results; no branch fields).
  - Both ports may write in the same cycle.
  - Same tag on both ports: CDB wins.
- Undefined: the ports are absent and only `CDB` writes entries.

## Test plan
- Reset, then 3 allocs with regs 1, 2, 3 → tags 0, 1, 2. Write back the tags in order 2, 0, 1 with data A/B/C → commits appear in order: tag 0 (reg 1, B), tag 1 (reg 2, C), tag 2 (reg 3, A), one per cycle.
- Allocate 16 without writeback → `ROB_full`=1 and the 17th request is ignored. Write back tag 0, commit → `ROB_full`=0; the next alloc gets tag 0 (wrap).
- Branch alloc with `pred_taken`=0, writeback `taken`=1, `pc`=0x1000 → at commit `clear`=1 for one cycle, `clear_pc`=0x1000, `ROB_reg_dest`=0. The next cycle has `count`=0 and the next alloc gets tag 0.
- Alloc and commit in the same cycle with `count`=5 → `count` stays 5, head and tail both advance.
- `rdy` low for 3 cycles with a ready head → no commit, no pointer change. `rdy` high → the commit occurs.
- Assert `rst_n` low asynchronously between edges with 4 entries live → all outputs go to 0 immediately and `ROB_full`=0.

Source files
------------

// File: rtl/rob_commit_if.sv
`default_nettype none
// ============================================================================
//  Module      : rob_commit_if
//  Description : Bundle of allocate, CDB writeback, commit and flush signals
//                between the reorder buffer and the rest of the core.
//                The optional second writeback port appears only when
//                ROB_CDB2_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface rob_commit_if #(
    parameter int TAG_W = 4
);
    // Allocation request from ID
    logic             ID_alloc_valid;
    logic [4:0]       ID_alloc_reg_dest;
    logic             ID_alloc_is_branch;
    logic             ID_alloc_pred_taken;
    logic [TAG_W-1:0] ROB_alloc_tag;
    logic             ROB_full;

    // Common data bus writeback
    logic             CDB_valid;
    logic [TAG_W-1:0] CDB_tag;
    logic [31:0]      CDB_data;
    logic             CDB_taken;
    logic [31:0]      CDB_pc;
`ifdef ROB_CDB2_EN
    logic             CDB2_valid;
    logic [TAG_W-1:0] CDB2_tag;
    logic [31:0]      CDB2_data;
`endif

    // Commit port towards the register file, plus flush
    logic             ROB_data_valid;
    logic [4:0]       ROB_reg_dest;
    logic [TAG_W-1:0] ROB_tag;
    logic [31:0]      ROB_data;
    logic             clear;
    logic [31:0]      clear_pc;

    // Core side: drives requests and results, observes the ROB
    modport master (
        output ID_alloc_valid, ID_alloc_reg_dest, ID_alloc_is_branch, ID_alloc_pred_taken,
        output CDB_valid, CDB_tag, CDB_data, CDB_taken, CDB_pc,
`ifdef ROB_CDB2_EN
        output CDB2_valid, CDB2_tag, CDB2_data,
`endif
        input  ROB_alloc_tag, ROB_full,
        input  ROB_data_valid, ROB_reg_dest, ROB_tag, ROB_data, clear, clear_pc
    );

    // ROB side
    modport slave (
        input  ID_alloc_valid, ID_alloc_reg_dest, ID_alloc_is_branch, ID_alloc_pred_taken,
        input  CDB_valid, CDB_tag, CDB_data, CDB_taken, CDB_pc,
`ifdef ROB_CDB2_EN
        input  CDB2_valid, CDB2_tag, CDB2_data,
`endif
        output ROB_alloc_tag, ROB_full,
        output ROB_data_valid, ROB_reg_dest, ROB_tag, ROB_data, clear, clear_pc
    );
endinterface
`default_nettype wire

// File: rtl/rob_commit.sv
`default_nettype none
// ============================================================================
//  Module      : rob_commit
//  Description : Reorder buffer. Hands out in-order tags, captures CDB
//                results, retires one completed entry per cycle in program
//                order and raises a one-cycle clear on a mispredicted branch.
//                Define ROB_CDB2_EN to add a second (LSB) writeback port.
//  Revision    : 1.0  initial release
// ============================================================================
module rob_commit #(
    parameter int ROB_DEPTH = 16,
    parameter int TAG_W     = 4
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    input  wire logic   rdy,
    rob_commit_if.slave bus
);
    localparam logic [TAG_W:0] c_FULL = (TAG_W+1)'(ROB_DEPTH);

    // Per-entry state
    logic [ROB_DEPTH-1:0] r_busy;
    logic [ROB_DEPTH-1:0] r_ready;
    logic [ROB_DEPTH-1:0] r_is_branch;
    logic [ROB_DEPTH-1:0] r_pred_taken;
    logic [ROB_DEPTH-1:0] r_taken;
    logic [4:0]           r_reg_dest [ROB_DEPTH];
    logic [31:0]          r_data     [ROB_DEPTH];
    logic [31:0]          r_pc       [ROB_DEPTH];

    // Pointers and occupancy
    logic [TAG_W-1:0]     r_head;
    logic [TAG_W-1:0]     r_tail;
    logic [TAG_W:0]       r_count;

    // Registered commit / flush outputs
    logic                 r_data_valid;
    logic [4:0]           r_out_dest;
    logic [TAG_W-1:0]     r_out_tag;
    logic [31:0]          r_out_data;
    logic                 r_clear;
    logic [31:0]          r_clear_pc;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_alloc;
    logic                 w_commit;
    logic                 w_mispredict;
    logic                 w_cdb_hit;
`ifdef ROB_CDB2_EN
    logic                 w_cdb2_hit;
`endif

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);

    // rdy gating lives in the sequential block, so these are per-edge intents.
    // While clear is high the whole buffer is being discarded: nothing else acts.
    assign w_alloc      = bus.ID_alloc_valid & ~w_full & ~r_clear;
    assign w_commit     = ~r_clear & ~w_empty & r_busy[r_head] & r_ready[r_head];
    assign w_mispredict = r_is_branch[r_head] & (r_taken[r_head] != r_pred_taken[r_head]);
    assign w_cdb_hit    = bus.CDB_valid & r_busy[bus.CDB_tag];
`ifdef ROB_CDB2_EN
    assign w_cdb2_hit   = bus.CDB2_valid & r_busy[bus.CDB2_tag];
`endif

    assign bus.ROB_alloc_tag  = r_tail;
    assign bus.ROB_full       = w_full;
    assign bus.ROB_data_valid = r_data_valid;
    assign bus.ROB_reg_dest   = r_out_dest;
    assign bus.ROB_tag        = r_out_tag;
    assign bus.ROB_data       = r_out_data;
    assign bus.clear          = r_clear;
    assign bus.clear_pc       = r_clear_pc;

    // Buffer state: writeback, in-order commit, allocation and flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy       <= '0;
            r_ready      <= '0;
            r_is_branch  <= '0;
            r_pred_taken <= '0;
            r_taken      <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_reg_dest[i] <= '0;
                r_data[i]     <= '0;
                r_pc[i]       <= '0;
            end
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_data_valid <= 1'b0;
            r_out_dest   <= '0;
            r_out_tag    <= '0;
            r_out_data   <= '0;
            r_clear      <= 1'b0;
            r_clear_pc   <= '0;
        end else if (rdy) begin
            if (r_clear) begin
                // Flush edge: every in-flight entry is wrong-path or already retired
                r_busy       <= '0;
                r_ready      <= '0;
                r_head       <= '0;
                r_tail       <= '0;
                r_count      <= '0;
                r_data_valid <= 1'b0;
                r_clear      <= 1'b0;
            end else begin
                // Writeback. CDB is applied last so it wins a same-tag collision.
`ifdef ROB_CDB2_EN
                if (w_cdb2_hit) begin
                    r_ready[bus.CDB2_tag] <= 1'b1;
                    r_data[bus.CDB2_tag]  <= bus.CDB2_data;
                end
`endif
                if (w_cdb_hit) begin
                    r_ready[bus.CDB_tag] <= 1'b1;
                    r_data[bus.CDB_tag]  <= bus.CDB_data;
                    r_taken[bus.CDB_tag] <= bus.CDB_taken;
                    r_pc[bus.CDB_tag]    <= bus.CDB_pc;
                end

                // Commit uses the pre-edge ready bit, so a result never
                // retires on the same edge it is written.
                if (w_commit) begin
                    r_busy[r_head]  <= 1'b0;
                    r_ready[r_head] <= 1'b0;
                    r_head          <= r_head + 1'b1;
                    // A mispredicted branch reports via clear instead of a commit
                    // pulse so the two are never high together.
                    r_data_valid    <= ~w_mispredict;
                    r_out_dest      <= r_is_branch[r_head] ? 5'd0 : r_reg_dest[r_head];
                    r_out_tag       <= r_head;
                    r_out_data      <= r_data[r_head];
                    r_clear         <= w_mispredict;
                    if (w_mispredict) begin
                        r_clear_pc <= r_pc[r_head];
                    end
                end else begin
                    r_data_valid <= 1'b0;
                    r_clear      <= 1'b0;
                end

                // Allocation is written after commit so it owns the slot if
                // it ever coincides with the entry being freed.
                if (w_alloc) begin
                    r_busy[r_tail]       <= 1'b1;
                    r_ready[r_tail]      <= 1'b0;
                    r_reg_dest[r_tail]   <= bus.ID_alloc_reg_dest;
                    r_is_branch[r_tail]  <= bus.ID_alloc_is_branch;
                    r_pred_taken[r_tail] <= bus.ID_alloc_pred_taken;
                    r_tail               <= r_tail + 1'b1;
                end

                r_count <= r_count + (TAG_W+1)'(w_alloc) - (TAG_W+1)'(w_commit);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rob_commit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rob_commit
//  Description : Self-checking bench for rob_commit: directed vector table,
//                hand-written corner sequences and random traffic against a
//                queue-based program-order model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rob_commit;
    logic clk;
    logic rst_n;
    logic rdy;
    int   checks   = 0;
    int   failures = 0;

    rob_commit_if #(.TAG_W(4)) bus ();

    rob_commit #(.ROB_DEPTH(16), .TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model: in-order queue of live entries -------
    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  dest;
        logic        br;
        logic        pred;
        logic        done;
        logic        tk;
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    int          m_tail;
    logic        m_dv, m_clear;
    logic [3:0]  m_tag;
    logic [4:0]  m_dest;
    logic [31:0] m_data, m_cpc;

    task automatic model_reset();
        q.delete();
        m_tail  = 0;
        m_dv    = 1'b0;
        m_clear = 1'b0;
        m_tag   = '0;
        m_dest  = '0;
        m_data  = '0;
        m_cpc   = '0;
    endtask

    // Next-edge effect of the current inputs on the model
    task automatic model_step();
        bit   do_commit, was_full, mis;
        ent_t h;
        ent_t n;
        if (!rdy) return;
        if (m_clear) begin
            q.delete();
            m_tail  = 0;
            m_dv    = 1'b0;
            m_clear = 1'b0;
            return;
        end
        was_full  = (q.size() == 16);
        do_commit = (q.size() > 0) && q[0].done;
        if (do_commit) h = q[0];
`ifdef ROB_CDB2_EN
        if (bus.CDB2_valid)
            foreach (q[i]) if (q[i].tag == bus.CDB2_tag) begin
                q[i].done = 1'b1;
                q[i].data = bus.CDB2_data;
            end
`endif
        if (bus.CDB_valid)
            foreach (q[i]) if (q[i].tag == bus.CDB_tag) begin
                q[i].done = 1'b1;
                q[i].data = bus.CDB_data;
                q[i].tk   = bus.CDB_taken;
                q[i].pc   = bus.CDB_pc;
            end
        if (do_commit) begin
            void'(q.pop_front());
            mis     = h.br && (h.tk != h.pred);
            m_dv    = !mis;
            m_clear = mis;
            m_tag   = h.tag;
            m_dest  = h.br ? 5'd0 : h.dest;
            m_data  = h.data;
            if (mis) m_cpc = h.pc;
        end else begin
            m_dv    = 1'b0;
            m_clear = 1'b0;
        end
        if (bus.ID_alloc_valid && !was_full) begin
            n.tag  = 4'(m_tail);
            n.dest = bus.ID_alloc_reg_dest;
            n.br   = bus.ID_alloc_is_branch;
            n.pred = bus.ID_alloc_pred_taken;
            n.done = 1'b0;
            n.tk   = 1'b0;
            n.data = '0;
            n.pc   = '0;
            q.push_back(n);
            m_tail = (m_tail + 1) % 16;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] dest, input logic br, input logic pred,
                         input logic cv, input logic [3:0] ctag, input logic [31:0] cdata,
                         input logic ctk, input logic [31:0] cpc);
        bus.ID_alloc_valid      = av;
        bus.ID_alloc_reg_dest   = dest;
        bus.ID_alloc_is_branch  = br;
        bus.ID_alloc_pred_taken = pred;
        bus.CDB_valid           = cv;
        bus.CDB_tag             = ctag;
        bus.CDB_data            = cdata;
        bus.CDB_taken           = ctk;
        bus.CDB_pc              = cpc;
`ifdef ROB_CDB2_EN
        bus.CDB2_valid          = 1'b0;
        bus.CDB2_tag            = '0;
        bus.CDB2_data           = '0;
`endif
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    endtask

    // One clock: check combinational outputs, update model, check registered outputs
    task automatic cycle();
        bit ok;
        #1;
        checks++;
        if (bus.ROB_alloc_tag !== 4'(m_tail) || bus.ROB_full !== (q.size() == 16)) begin
            failures++;
            $display("FAIL model_comb: tag=%0d full=%0b expected tag=%0d full=%0b",
                     bus.ROB_alloc_tag, bus.ROB_full, m_tail, (q.size() == 16));
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
        ok = (bus.ROB_data_valid === m_dv) && (bus.clear === m_clear);
        if (m_dv || m_clear) ok = ok && (bus.ROB_tag === m_tag) && (bus.ROB_reg_dest === m_dest);
        if (m_dv)            ok = ok && (bus.ROB_data === m_data);
        if (m_clear)         ok = ok && (bus.clear_pc === m_cpc);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL model_reg: dv=%0b clr=%0b tag=%0d dest=%0d data=%h cpc=%h expected dv=%0b clr=%0b tag=%0d dest=%0d data=%h cpc=%h",
                     bus.ROB_data_valid, bus.clear, bus.ROB_tag, bus.ROB_reg_dest, bus.ROB_data, bus.clear_pc,
                     m_dv, m_clear, m_tag, m_dest, m_data, m_cpc);
        end
    endtask

    task automatic apply_reset();
        idle();
        rdy   = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        av;
        logic [4:0]  dest;
        logic        cv;
        logic [3:0]  ctag;
        logic [31:0] cdata;
        logic [3:0]  e_atag;
        logic        e_dv;
        logic [3:0]  e_tag;
        logic [4:0]  e_dest;
        logic [31:0] e_data;
    } vec_t;

    vec_t vt[9];

    localparam logic [31:0] c_A = 32'h0000_00A1;
    localparam logic [31:0] c_B = 32'h0000_00B2;
    localparam logic [31:0] c_C = 32'h0000_00C3;

    initial begin
        vt[0] = '{1'b1, 5'd1, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 5'd0, 32'd0};
        vt[1] = '{1'b1, 5'd2, 1'b0, 4'd0, 32'd0, 4'd1, 1'b0, 4'd0, 5'd0, 32'd0};
        vt[2] = '{1'b1, 5'd3, 1'b0, 4'd0, 32'd0, 4'd2, 1'b0, 4'd0, 5'd0, 32'd0};
        vt[3] = '{1'b0, 5'd0, 1'b1, 4'd2, c_A,   4'd3, 1'b0, 4'd0, 5'd0, 32'd0};
        vt[4] = '{1'b0, 5'd0, 1'b1, 4'd0, c_B,   4'd3, 1'b0, 4'd0, 5'd0, 32'd0};
        vt[5] = '{1'b0, 5'd0, 1'b1, 4'd1, c_C,   4'd3, 1'b1, 4'd0, 5'd1, c_B};
        vt[6] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd3, 1'b1, 4'd1, 5'd2, c_C};
        vt[7] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd3, 1'b1, 4'd2, 5'd3, c_A};
        vt[8] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd3, 1'b0, 4'd0, 5'd0, 32'd0};

        // ---- reset state ----
        rst_n = 1'b0;
        rdy   = 1'b1;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_dv",    32'(bus.ROB_data_valid), 32'd0);
        chk("rst_clear", 32'(bus.clear),          32'd0);
        chk("rst_atag",  32'(bus.ROB_alloc_tag),  32'd0);
        chk("rst_full",  32'(bus.ROB_full),       32'd0);
        rst_n = 1'b1;

        // ---- out-of-order writeback, in-order commit ----
        for (int i = 0; i < 9; i++) begin
            drive(vt[i].av, vt[i].dest, 1'b0, 1'b0, vt[i].cv, vt[i].ctag, vt[i].cdata, 1'b0, 32'd0);
            #1;
            chk("tbl_atag", 32'(bus.ROB_alloc_tag), 32'(vt[i].e_atag));
            cycle();
            chk("tbl_dv", 32'(bus.ROB_data_valid), 32'(vt[i].e_dv));
            if (vt[i].e_dv) begin
                chk("tbl_tag",  32'(bus.ROB_tag),      32'(vt[i].e_tag));
                chk("tbl_dest", 32'(bus.ROB_reg_dest), 32'(vt[i].e_dest));
                chk("tbl_data", bus.ROB_data,          vt[i].e_data);
            end
        end

        // ---- fill to 16, 17th ignored, free one, wrap to tag 0 ----
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 5'(i + 1), 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
            cycle();
        end
        chk("full_set", 32'(bus.ROB_full), 32'd1);
        drive(1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        cycle();
        chk("full_17th_ignored", 32'(dut.r_count), 32'd16);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h1234_5678, 1'b0, 32'd0);
        cycle();
        idle();
        cycle();
        chk("full_commit_dv",  32'(bus.ROB_data_valid), 32'd1);
        chk("full_commit_tag", 32'(bus.ROB_tag),        32'd0);
        chk("full_cleared",    32'(bus.ROB_full),       32'd0);
        drive(1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        #1;
        chk("wrap_atag", 32'(bus.ROB_alloc_tag), 32'd0);
        cycle();

        // ---- mispredicted branch ----
        apply_reset();
        drive(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        cycle();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0000_0055, 1'b1, 32'h0000_1000);
        cycle();
        idle();
        cycle();
        chk("mis_clear",    32'(bus.clear),          32'd1);
        chk("mis_clear_pc", bus.clear_pc,            32'h0000_1000);
        chk("mis_dest",     32'(bus.ROB_reg_dest),   32'd0);
        chk("mis_no_dv",    32'(bus.ROB_data_valid), 32'd0);
        drive(1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        cycle();
        chk("mis_pulse_end", 32'(bus.clear),   32'd0);
        chk("mis_count0",    32'(dut.r_count), 32'd0);
        drive(1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        #1;
        chk("mis_next_atag", 32'(bus.ROB_alloc_tag), 32'd0);
        cycle();

        // ---- simultaneous alloc and commit at count 5 ----
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'(10 + i), 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
            cycle();
        end
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd0, 32'hCAFE_0000, 1'b0, 32'd0);
        cycle();
        drive(1'b1, 5'd20, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        cycle();
        chk("ac_count",  32'(dut.r_count),       32'd5);
        chk("ac_dv",     32'(bus.ROB_data_valid), 32'd1);
        chk("ac_atag",   32'(bus.ROB_alloc_tag), 32'd6);

        // ---- rdy low freezes a ready head ----
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd1, 32'hBEEF_0001, 1'b0, 32'd0);
        cycle();
        idle();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd21, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
            cycle();
            chk("rdy_hold_dv",    32'(bus.ROB_data_valid), 32'd0);
            chk("rdy_hold_atag",  32'(bus.ROB_alloc_tag),  32'd6);
        end
        idle();
        rdy = 1'b1;
        cycle();
        chk("rdy_commit_dv",   32'(bus.ROB_data_valid), 32'd1);
        chk("rdy_commit_tag",  32'(bus.ROB_tag),        32'd1);
        chk("rdy_commit_data", bus.ROB_data,            32'hBEEF_0001);

        // ---- asynchronous reset between edges with 4 live entries ----
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dv",    32'(bus.ROB_data_valid), 32'd0);
        chk("arst_tag",   32'(bus.ROB_tag),        32'd0);
        chk("arst_data",  bus.ROB_data,            32'd0);
        chk("arst_dest",  32'(bus.ROB_reg_dest),   32'd0);
        chk("arst_clear", 32'(bus.clear) | 32'(bus.clear_pc), 32'd0);
        chk("arst_atag",  32'(bus.ROB_alloc_tag),  32'd0);
        chk("arst_full",  32'(bus.ROB_full),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // ---- random traffic against the model ----
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] ct;
            if (q.size() > 0 && $urandom_range(0, 4) != 0)
                ct = q[$urandom_range(0, q.size() - 1)].tag;
            else
                ct = 4'($urandom_range(0, 15));
            drive(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 1), ct, $urandom(),
                  1'($urandom_range(0, 1)), $urandom());
`ifdef ROB_CDB2_EN
            bus.CDB2_valid = ($urandom_range(0, 2) == 0);
            bus.CDB2_tag   = (q.size() > 0) ? q[$urandom_range(0, q.size() - 1)].tag : 4'd0;
            bus.CDB2_data  = $urandom();
`endif
            rdy = ($urandom_range(0, 9) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
